// File: rtl/register_bank.sv
// Addressed bank of NUM_REGS registers with per-register mode (RW, RO status, W1C flags)
// behind a two-cycle req/ack access port with byte enables.
module register_bank #(
  parameter int                          NUM_REGS     = 8,
  parameter int                          WIDTH        = 16,
  parameter int                          ADDR_W       = 3,
  parameter logic [NUM_REGS*WIDTH-1:0]   RESET_VALUES = '0,
  parameter logic [NUM_REGS-1:0]         RO_MASK      = '0,
  parameter logic [NUM_REGS-1:0]         W1C_MASK     = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req,
  input  logic                      wr,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [WIDTH/8-1:0]        be,
  input  logic [WIDTH-1:0]          wdata,
  output logic                      ack,
  output logic [WIDTH-1:0]          rdata,
  output logic                      err,
  input  logic [NUM_REGS*WIDTH-1:0] hw_val,
  input  logic [NUM_REGS*WIDTH-1:0] hw_set,
  output logic [NUM_REGS*WIDTH-1:0] reg_out
);

  localparam int NB = WIDTH / 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t             state;
  state_t             next_state;
  logic               accept;
  logic               wr_en;
  logic               in_range;
  logic               hit_ro;
  logic [NUM_REGS-1:0] sel;
  logic [WIDTH-1:0]   rd_val;
  logic [WIDTH-1:0]   wmask;
  logic [WIDTH-1:0]   regs [NUM_REGS];

  // Expand per-byte enables into a per-bit write mask.
  function automatic logic [WIDTH-1:0] lane_mask(input logic [NB-1:0] lanes);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int b = 0; b < NB; b++) begin
      m[b*8 +: 8] = {8{lanes[b]}};
    end
    return m;
  endfunction

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next state; an access is taken only on an IDLE edge with req high.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          next_state = RESP;
          accept     = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Address decode and read mux; unmatched addresses leave sel empty and rd_val zero.
  always_comb begin
    sel    = '0;
    rd_val = '0;
    hit_ro = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr == ADDR_W'(i)) begin
        sel[i] = 1'b1;
        rd_val = regs[i];
        hit_ro = RO_MASK[i];
      end else begin
        sel[i] = 1'b0;
      end
    end
  end

  assign in_range = |sel;
  assign wr_en    = accept & wr;
  assign wmask    = lane_mask(be);

  // Response registers: ack/err live only in the RESP cycle, rdata holds between accesses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack   <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      ack <= accept;
      if (accept) begin
        err   <= ~in_range | (wr & hit_ro);
        rdata <= wr ? {WIDTH{1'b0}} : rd_val;
      end else begin
        err   <= 1'b0;
        rdata <= rdata;
      end
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    localparam logic [WIDTH-1:0] RV = RESET_VALUES[i*WIDTH +: WIDTH];
    logic             write_hit;
    logic [WIDTH-1:0] q;

    assign write_hit = wr_en & sel[i];

    if (RO_MASK[i]) begin : g_ro
      // Status register: registered copy of the hardware value, bus writes rejected.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          q <= RV;
        end else begin
          q <= hw_val[i*WIDTH +: WIDTH];
        end
      end
    end else if (W1C_MASK[i]) begin : g_w1c
      // Event flags: hardware sets, bus clears with 1s; the set term is applied last so it wins.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          q <= RV;
        end else begin
          q <= (q & ~(write_hit ? (wmask & wdata) : {WIDTH{1'b0}}))
               | hw_set[i*WIDTH +: WIDTH];
        end
      end
    end else begin : g_rw
      // Plain read-write register with byte-lane merge.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          q <= RV;
        end else if (write_hit) begin
          q <= (q & ~wmask) | (wdata & wmask);
        end else begin
          q <= q;
        end
      end
    end

    assign regs[i]                    = q;
    assign reg_out[i*WIDTH +: WIDTH]  = q;
  end

  // Not every register mode consumes its hw_val / hw_set slice.
  logic unused_hw_inputs;
  assign unused_hw_inputs = ^{hw_val, hw_set};

endmodule

// File: tb/tb_register_bank.sv
// Scoreboard bench for register_bank: responses are predicted at request time and
// compared when ack arrives; register contents are tracked by a small model.
module tb_register_bank;

  localparam int N  = 6;
  localparam int W  = 16;
  localparam int AW = 3;
  localparam logic [N*W-1:0] RV  = {16'h0000, 16'h0000, 16'h0000, 16'h00A5, 16'h0000, 16'h0000};
  localparam logic [N-1:0]   RO  = 6'b100000;
  localparam logic [N-1:0]   W1C = 6'b001000;

  logic          clk;
  logic          reset;
  logic          req;
  logic          wr;
  logic [AW-1:0] addr;
  logic [1:0]    be;
  logic [W-1:0]  wdata;
  logic          ack;
  logic [W-1:0]  rdata;
  logic          err;
  logic [N*W-1:0] hw_val;
  logic [N*W-1:0] hw_set;
  logic [N*W-1:0] reg_out;

  int          checks;
  int          failures;
  logic [31:0] exp_q[$];
  logic [W-1:0] mdl[N];

  register_bank #(
    .NUM_REGS(N), .WIDTH(W), .ADDR_W(AW),
    .RESET_VALUES(RV), .RO_MASK(RO), .W1C_MASK(W1C)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .addr(addr), .be(be),
    .wdata(wdata), .ack(ack), .rdata(rdata), .err(err),
    .hw_val(hw_val), .hw_set(hw_set), .reg_out(reg_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Response monitor: pop the prediction on every ack.
  always @(negedge clk) begin
    logic [31:0] e;
    if (ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_ack", 32'(ack), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("resp", {15'd0, err, rdata}, e);
      end
    end
  end

  task automatic check_regs(input string tag);
    for (int i = 0; i < N; i++) begin
      check_eq(tag, {16'd0, reg_out[i*W +: W]}, {16'd0, mdl[i]});
    end
  endtask

  task automatic access(input logic w, input logic [AW-1:0] a, input logic [1:0] b,
                        input logic [W-1:0] d, input logic [W-1:0] hs3);
    logic         inr;
    logic         e_err;
    logic [W-1:0] e_rd;
    logic [W-1:0] m;
    int           lat;
    inr   = (a < N);
    e_err = !inr || (w && a == 3'd5);
    e_rd  = (!w && inr) ? mdl[a] : 16'h0000;
    @(posedge clk); #1;
    req = 1'b1; wr = w; addr = a; be = b; wdata = d;
    hw_set = '0;
    hw_set[3*W +: W] = hs3;
    exp_q.push_back({15'd0, e_err, e_rd});
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (ack !== 1'b1 && lat < 5);
    check_eq("ack_latency", lat, 1);
    req    = 1'b0;
    hw_set = '0;
    m = {{8{b[1]}}, {8{b[0]}}};
    if (w && inr) begin
      if (a == 3'd3) mdl[3] = mdl[3] & ~(m & d);
      else if (a != 3'd5) mdl[a] = (mdl[a] & ~m) | (d & m);
    end
    mdl[3] = mdl[3] | hs3;
    check_regs("reg_out");
    @(posedge clk); #1;
    check_eq("ack_pulse", {31'd0, ack}, 32'd0);
    check_eq("err_idle", {31'd0, err}, 32'd0);
  endtask

  task automatic pulse_set3(input logic [W-1:0] v);
    @(posedge clk); #1;
    hw_set[3*W +: W] = v;
    @(posedge clk); #1;
    hw_set = '0;
    mdl[3] = mdl[3] | v;
    check_eq("hw_set", {16'd0, reg_out[3*W +: W]}, {16'd0, mdl[3]});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    checks = 0; failures = 0;
    reset = 1'b0; req = 1'b0; wr = 1'b0; addr = '0; be = 2'b00; wdata = '0;
    hw_set = '0; hw_val = '0;
    hw_val[5*W +: W] = 16'hBEEF;
    for (int i = 0; i < N; i++) mdl[i] = RV[i*W +: W];

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ack", {31'd0, ack}, 32'd0);
    check_eq("rst_err", {31'd0, err}, 32'd0);
    check_eq("rst_rdata", {16'd0, rdata}, 32'd0);
    check_regs("rst_reg_out");

    // Request pending when reset hits: the access must be dropped.
    reset = 1'b1;
    @(posedge clk); #1;
    req = 1'b1; wr = 1'b1; addr = 3'd2; be = 2'b11; wdata = 16'hFFFF;
    #2 reset = 1'b0;
    @(posedge clk); #1;
    check_eq("midrst_ack", {31'd0, ack}, 32'd0);
    check_eq("midrst_rdata", {16'd0, rdata}, 32'd0);
    check_eq("midrst_reg2", {16'd0, reg_out[2*W +: W]}, 32'h00A5);
    req = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    mdl[5] = 16'hBEEF;

    access(1'b0, 3'd2, 2'b11, 16'h0000, 16'h0000);
    pulse_set3(16'h00FF);
    access(1'b1, 3'd1, 2'b11, 16'h1234, 16'h0000);
    access(1'b1, 3'd1, 2'b10, 16'hABCD, 16'h0000);
    access(1'b0, 3'd1, 2'b11, 16'h0000, 16'h0000);
    access(1'b1, 3'd3, 2'b11, 16'h000F, 16'h0000);
    access(1'b1, 3'd3, 2'b11, 16'h0010, 16'h0010);
    access(1'b0, 3'd3, 2'b11, 16'h0000, 16'h0000);
    access(1'b0, 3'd3, 2'b11, 16'h0000, 16'h0000);
    access(1'b1, 3'd3, 2'b01, 16'hFF00, 16'h0000);
    access(1'b0, 3'd5, 2'b11, 16'h0000, 16'h0000);
    access(1'b1, 3'd5, 2'b11, 16'h0000, 16'h0000);
    access(1'b0, 3'd5, 2'b11, 16'h0000, 16'h0000);
    access(1'b0, 3'd7, 2'b11, 16'h0000, 16'h0000);
    access(1'b1, 3'd6, 2'b11, 16'h5555, 16'h0000);
    access(1'b1, 3'd0, 2'b11, 16'h7E81, 16'h0000);
    access(1'b1, 3'd0, 2'b00, 16'hFFFF, 16'h0000);
    access(1'b1, 3'd0, 2'b01, 16'h1122, 16'h0000);

    // Back-to-back: req held high, one write per ack, ack every second cycle.
    @(posedge clk); #1;
    req = 1'b1; wr = 1'b1; addr = 3'd0; be = 2'b11; wdata = 16'h1000;
    exp_q.push_back(32'd0);
    k = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      check_eq("hs_ack", {31'd0, ack}, 32'((n % 2) == 0));
      if (ack === 1'b1) begin
        check_eq("hs_reg0", {16'd0, reg_out[0 +: W]}, 32'h1000 + 32'(k));
        k++;
        if (k < 4) begin
          wdata = 16'h1000 + 16'(k);
          exp_q.push_back(32'd0);
        end
      end
    end
    req = 1'b0;
    mdl[0] = 16'h1003;
    repeat (2) @(posedge clk);
    #1;
    check_regs("final_reg_out");
    check_eq("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
